// File: rtl/banner_scroller.sv
// banner_scroller: rotates a loadable hex-digit message through a 7-segment window
// one digit per tick, holding for a programmable number of ticks at each wrap.
module banner_scroller #(
    parameter int MSG_LEN     = 10,
    parameter int DIGITS      = 4,
    parameter int PAUSE_TICKS = 3,
    localparam int PW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1,
    localparam int CW = (PAUSE_TICKS > 0) ? $clog2(PAUSE_TICKS + 1) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tick,
    input  logic                  load,
    input  logic [4*MSG_LEN-1:0]  msg_in,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  dir,
    output logic [4*DIGITS-1:0]   window,
    output logic [PW-1:0]         pos,
    output logic                  busy,
    output logic                  wrap
);

    typedef enum logic [1:0] {IDLE, SCROLL, PAUSE} state_t;

    state_t               state_q, state_d;
    logic [4*MSG_LEN-1:0] msg_q, msg_d, rol, ror;
    logic [PW-1:0]        pos_q, pos_d, pos_step;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 wrap_q, wrap_d;

    // Nibble 0 in bit order is the last message digit, so a left scroll moves
    // every nibble up one slot and brings the top nibble round to the bottom.
    always_comb begin
        rol = '0;
        ror = '0;
        for (int i = 0; i < MSG_LEN; i++) begin
            rol[4*i +: 4] = msg_q[4*((i + MSG_LEN - 1) % MSG_LEN) +: 4];
            ror[4*i +: 4] = msg_q[4*((i + 1) % MSG_LEN) +: 4];
        end
    end

    always_comb begin
        pos_step = dir ? ((pos_q == '0) ? PW'(MSG_LEN - 1) : pos_q - PW'(1))
                       : ((pos_q == PW'(MSG_LEN - 1)) ? '0 : pos_q + PW'(1));
    end

    always_comb begin
        state_d = state_q;
        msg_d   = msg_q;
        pos_d   = pos_q;
        cnt_d   = cnt_q;
        wrap_d  = 1'b0;
        if (load) begin
            msg_d   = msg_in;
            pos_d   = '0;
            cnt_d   = '0;
            state_d = IDLE;
        end else if (stop && state_q != IDLE) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (start && state_q == IDLE) begin
            state_d = SCROLL;
        end else if (tick && state_q == SCROLL) begin
            msg_d = dir ? ror : rol;
            pos_d = pos_step;
            if (pos_step == '0) begin
                wrap_d = 1'b1;
                if (PAUSE_TICKS > 0) begin
                    state_d = PAUSE;
                    cnt_d   = '0;
                end
            end
        end else if (tick && state_q == PAUSE) begin
            cnt_d   = cnt_q + CW'(1);
            state_d = (cnt_q + CW'(1) == CW'(PAUSE_TICKS)) ? SCROLL : PAUSE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            msg_q   <= '0;
            pos_q   <= '0;
            cnt_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            msg_q   <= msg_d;
            pos_q   <= pos_d;
            cnt_q   <= cnt_d;
            wrap_q  <= wrap_d;
        end
    end

    assign window = msg_q[4*MSG_LEN-1 -: 4*DIGITS];
    assign pos    = pos_q;
    assign busy   = (state_q != IDLE);
    assign wrap   = wrap_q;

endmodule

// File: tb/tb_banner_scroller.sv
// tb_banner_scroller: directed checks of banner_scroller with the default pause
// and a second instance with the pause disabled, both driven by the same inputs.
module tb_banner_scroller;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        tick = 1'b0, load = 1'b0, start = 1'b0, stop = 1'b0, dir = 1'b0;
    logic [39:0] msg_in = '0;
    logic [15:0] window, window0;
    logic [3:0]  pos, pos0;
    logic        busy, busy0, wrap, wrap0;
    int          n_chk = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    banner_scroller dut (
        .clk(clk), .reset(reset), .tick(tick), .load(load), .msg_in(msg_in),
        .start(start), .stop(stop), .dir(dir),
        .window(window), .pos(pos), .busy(busy), .wrap(wrap)
    );

    banner_scroller #(.PAUSE_TICKS(0)) dut0 (
        .clk(clk), .reset(reset), .tick(tick), .load(load), .msg_in(msg_in),
        .start(start), .stop(stop), .dir(dir),
        .window(window0), .pos(pos0), .busy(busy0), .wrap(wrap0)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            cyc();
            tick = 1'b0;
        end
    endtask

    task automatic do_load(input logic [39:0] m);
        msg_in = m;
        load   = 1'b1;
        cyc();
        load   = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    initial begin
        #12;
        chk("rst_window", window, 16'h0);
        chk("rst_busy", busy, 0);
        chk("rst_wrap", wrap, 0);
        chk("rst_pos", pos, 0);
        @(negedge clk);
        reset = 1'b1;
        cyc();

        do_load(40'h0123456789);
        chk("load_window", window, 16'h0123);
        chk("load_pos", pos, 0);
        chk("load_busy", busy, 0);
        ticks(2);
        chk("idle_tick_window", window, 16'h0123);
        chk("idle_tick_busy", busy, 0);

        do_start();
        chk("start_busy", busy, 1);
        chk("start_window", window, 16'h0123);
        ticks(1);
        chk("left1_window", window, 16'h1234);
        chk("left1_pos", pos, 1);
        ticks(8);
        chk("left9_window", window, 16'h9012);
        chk("left9_pos", pos, 9);
        chk("left9_wrap", wrap, 0);
        ticks(1);
        chk("left_wrap_window", window, 16'h0123);
        chk("left_wrap_pos", pos, 0);
        chk("left_wrap_pulse", wrap, 1);
        chk("left_wrap_busy", busy, 1);
        chk("nopause_wrap_pulse", wrap0, 1);
        cyc();
        chk("left_wrap_one_cycle", wrap, 0);
        chk("nopause_wrap_one_cycle", wrap0, 0);
        ticks(1);
        chk("pause1_pos", pos, 0);
        chk("nopause_step_pos", pos0, 1);
        chk("nopause_step_window", window0, 16'h1234);
        ticks(2);
        chk("pause3_window", window, 16'h0123);
        chk("pause3_pos", pos, 0);
        ticks(1);
        chk("post_pause_window", window, 16'h1234);
        chk("post_pause_pos", pos, 1);

        do_load(40'h0123456789);
        do_start();
        dir = 1'b1;
        ticks(1);
        chk("right1_window", window, 16'h9012);
        chk("right1_pos", pos, 9);
        chk("right1_wrap", wrap, 0);
        ticks(8);
        chk("right9_window", window, 16'h1234);
        chk("right9_pos", pos, 1);
        ticks(1);
        chk("right_wrap_window", window, 16'h0123);
        chk("right_wrap_pos", pos, 0);
        chk("right_wrap_pulse", wrap, 1);

        stop = 1'b1; tick = 1'b1;
        cyc();
        stop = 1'b0; tick = 1'b0;
        chk("stop_pause_busy", busy, 0);
        chk("stop_pause_window", window, 16'h0123);
        start = 1'b1; tick = 1'b1;
        cyc();
        start = 1'b0; tick = 1'b0;
        chk("start_tick_busy", busy, 1);
        chk("start_tick_noshift", window, 16'h0123);
        ticks(1);
        chk("start_tick_next_shift", window, 16'h9012);
        chk("start_tick_next_pos", pos, 9);
        dir = 1'b0;
        ticks(1);
        chk("dir_flip_window", window, 16'h0123);
        chk("dir_flip_pos", pos, 0);
        chk("dir_flip_wrap", wrap, 1);

        do_load(40'hFEDCBA9876);
        do_start();
        ticks(1);
        chk("scroll_before_load", window, 16'hEDCB);
        msg_in = 40'h0123456789; load = 1'b1; tick = 1'b1;
        cyc();
        load = 1'b0; tick = 1'b0;
        chk("load_tick_window", window, 16'h0123);
        chk("load_tick_pos", pos, 0);
        chk("load_tick_busy", busy, 0);
        chk("load_tick_wrap", wrap, 0);

        do_start();
        ticks(1);
        stop = 1'b1; tick = 1'b1;
        cyc();
        stop = 1'b0; tick = 1'b0;
        chk("stop_tick_busy", busy, 0);
        chk("stop_tick_window", window, 16'h1234);
        chk("stop_tick_pos", pos, 1);

        do_load(40'h0123456789);
        do_start();
        ticks(10);
        chk("pre_reset_wrap", wrap, 1);
        #2 reset = 1'b0;
        #1;
        chk("async_window", window, 16'h0);
        chk("async_busy", busy, 0);
        chk("async_wrap", wrap, 0);
        chk("async_pos", pos, 0);
        chk("async_busy0", busy0, 0);
        @(negedge clk);
        reset = 1'b1;
        ticks(3);
        chk("post_reset_window", window, 16'h0);
        chk("post_reset_busy", busy, 0);
        chk("post_reset_pos", pos, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
